// File: rtl/rty_cmd_sched.sv
// ---------------------------------------------------------------------------
// rty_cmd_sched
//
// Purpose:
//   Shares the single command-issue slot between new commands (command
//   engine) and retry requests (retry queue). New commands normally own the
//   slot. While the retry queue is busy, a retry window of at most RTY_WINDOW
//   cycles opens after CMD_BURST new-command handshakes, or as soon as no new
//   command is requesting. A credit counter limits outstanding commands. The
//   partial-command-start pulse for the retry queue is also generated here.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   cmd_valid/cmd_rdy               new-command handshake
//   cmd_tag/cmd_pos/cmd_partial     new-command payload
//   rty_busy                        retry queue non-empty
//   rty_rdy/rty_valid               retry handshake (rty_valid only while rty_rdy)
//   rty_tag/rty_pos                 retry payload
//   cmd_done                        one-cycle credit return
//   out_valid/out_rdy               issued-command handshake
//   out_tag/out_pos/out_is_retry    issued-command payload
//   prt_cmd_start                   pulse: partial new command accepted
//   credit_err                      sticky: credit return overflow
//
// Configuration:
//   RTY_CMD_SCHED_STATS_EN  when defined, adds stat_rty_cnt, stat_win_timeout
//                           and stat_stall counters (all wrap, reset to 0).
// ---------------------------------------------------------------------------
module rty_cmd_sched #(
  parameter int TAGW       = 7,
  parameter int CREDITS    = 32,
  parameter int CMD_BURST  = 8,
  parameter int RTY_WINDOW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_rdy,
  input  logic [TAGW-1:0] cmd_tag,
  input  logic [1:0]      cmd_pos,
  input  logic            cmd_partial,
  input  logic            rty_busy,
  output logic            rty_rdy,
  input  logic            rty_valid,
  input  logic [TAGW-1:0] rty_tag,
  input  logic [1:0]      rty_pos,
  input  logic            cmd_done,
  output logic            out_valid,
  input  logic            out_rdy,
  output logic [TAGW-1:0] out_tag,
  output logic [1:0]      out_pos,
  output logic            out_is_retry,
  output logic            prt_cmd_start,
  output logic            credit_err
`ifdef RTY_CMD_SCHED_STATS_EN
  ,
  output logic [31:0]     stat_rty_cnt,
  output logic [15:0]     stat_win_timeout,
  output logic [31:0]     stat_stall
`endif
);

  localparam int CNTW = $clog2(CREDITS) + 1;
  localparam int BW   = $clog2(CMD_BURST + 1);
  localparam int WW   = $clog2(RTY_WINDOW + 1);

  typedef enum logic {
    CMD_WIN = 1'b0,
    RTY_WIN = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [CNTW-1:0]   credit_cnt_q, credit_cnt_d;
  logic [BW-1:0]     burst_cnt_q, burst_cnt_d;
  logic [WW-1:0]     win_cnt_q, win_cnt_d;
  logic              credit_err_q, credit_err_d;
  logic              out_valid_q, out_valid_d;
  logic [TAGW-1:0]   out_tag_q, out_tag_d;
  logic [1:0]        out_pos_q, out_pos_d;
  logic              out_is_retry_q, out_is_retry_d;
  logic              prt_cmd_start_q, prt_cmd_start_d;

  logic slot_free, credit_ok;
  logic cmd_hs, rty_hs, any_hs;
  logic burst_last, win_last, win_timeout;

  // Readies depend only on state, output occupancy and credits, never on a
  // valid input, so upstream may form valid from ready without a loop.
  always_comb begin
    slot_free = ~out_valid_q | out_rdy;
    credit_ok = (credit_cnt_q != '0);
    cmd_rdy   = (state_q == CMD_WIN) & slot_free & credit_ok;
    rty_rdy   = (state_q == RTY_WIN) & slot_free & credit_ok;
    cmd_hs    = cmd_valid & cmd_rdy;
    rty_hs    = rty_valid;
    any_hs    = cmd_hs | rty_hs;
  end

  // Scheduler window control.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    win_cnt_d   = win_cnt_q;
    win_timeout = 1'b0;
    burst_last  = (burst_cnt_q == BW'(CMD_BURST - 1));
    win_last    = (win_cnt_q == WW'(RTY_WINDOW - 1));
    unique case (state_q)
      CMD_WIN: begin
        if (rty_busy & (~cmd_valid | (cmd_hs & burst_last))) begin
          state_d     = RTY_WIN;
          burst_cnt_d = '0;
          win_cnt_d   = '0;
        end else if (cmd_hs & ~burst_last) begin
          // Saturates at CMD_BURST-1 while the retry queue stays empty.
          burst_cnt_d = burst_cnt_q + 1'b1;
        end
      end
      RTY_WIN: begin
        // Window time runs even when the slot or credits are unavailable.
        win_cnt_d = win_cnt_q + 1'b1;
        if (rty_hs | ~rty_busy | win_last) state_d = CMD_WIN;
        // A retry accepted on the last window cycle is not a timeout.
        win_timeout = win_last & ~rty_hs;
      end
      default: state_d = CMD_WIN;
    endcase
  end

  // Credits, output register and partial-start pulse.
  always_comb begin
    credit_cnt_d    = credit_cnt_q;
    credit_err_d    = credit_err_q;
    out_valid_d     = out_valid_q;
    out_tag_d       = out_tag_q;
    out_pos_d       = out_pos_q;
    out_is_retry_d  = out_is_retry_q;
    prt_cmd_start_d = cmd_hs & cmd_partial;

    unique case ({any_hs, cmd_done})
      2'b10: credit_cnt_d = credit_cnt_q - 1'b1;
      2'b01: begin
        if (credit_cnt_q == CNTW'(CREDITS)) credit_err_d = 1'b1;
        else                                credit_cnt_d = credit_cnt_q + 1'b1;
      end
      default: ;  // idle, or issue and return cancel out
    endcase

    if (any_hs) begin
      out_valid_d    = 1'b1;
      out_tag_d      = cmd_hs ? cmd_tag : rty_tag;
      out_pos_d      = cmd_hs ? cmd_pos : rty_pos;
      out_is_retry_d = ~cmd_hs;
    end else if (out_rdy) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: the output payload fields are reset along with out_valid because
  // they are visible ports that must read zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= CMD_WIN;
      credit_cnt_q    <= CNTW'(CREDITS);
      burst_cnt_q     <= '0;
      win_cnt_q       <= '0;
      credit_err_q    <= 1'b0;
      out_valid_q     <= 1'b0;
      out_tag_q       <= '0;
      out_pos_q       <= '0;
      out_is_retry_q  <= 1'b0;
      prt_cmd_start_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every flop samples the pre-edge
      // values computed above regardless of statement order.
      state_q         <= state_d;
      credit_cnt_q    <= credit_cnt_d;
      burst_cnt_q     <= burst_cnt_d;
      win_cnt_q       <= win_cnt_d;
      credit_err_q    <= credit_err_d;
      out_valid_q     <= out_valid_d;
      out_tag_q       <= out_tag_d;
      out_pos_q       <= out_pos_d;
      out_is_retry_q  <= out_is_retry_d;
      prt_cmd_start_q <= prt_cmd_start_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_tag       = out_tag_q;
  assign out_pos       = out_pos_q;
  assign out_is_retry  = out_is_retry_q;
  assign prt_cmd_start = prt_cmd_start_q;
  assign credit_err    = credit_err_q;

`ifdef RTY_CMD_SCHED_STATS_EN
  logic [31:0] stat_rty_cnt_q, stat_rty_cnt_d;
  logic [15:0] stat_win_timeout_q, stat_win_timeout_d;
  logic [31:0] stat_stall_q, stat_stall_d;

  always_comb begin
    stat_rty_cnt_d     = stat_rty_cnt_q + {31'd0, rty_hs};
    stat_win_timeout_d = stat_win_timeout_q + {15'd0, win_timeout};
    stat_stall_d       = stat_stall_q + {31'd0, ~credit_ok};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_rty_cnt_q     <= '0;
      stat_win_timeout_q <= '0;
      stat_stall_q       <= '0;
    end else begin
      stat_rty_cnt_q     <= stat_rty_cnt_d;
      stat_win_timeout_q <= stat_win_timeout_d;
      stat_stall_q       <= stat_stall_d;
    end
  end

  assign stat_rty_cnt     = stat_rty_cnt_q;
  assign stat_win_timeout = stat_win_timeout_q;
  assign stat_stall       = stat_stall_q;
`endif

endmodule

// File: tb/tb_rty_cmd_sched.sv
// ---------------------------------------------------------------------------
// tb_rty_cmd_sched
//
// Self-checking bench for rty_cmd_sched (default parameters). Each scenario
// task drives inputs one point after the rising edge and compares ready/status
// outputs against values it derives itself. Accepted transfers push their
// expected payload into a scoreboard queue; a negedge monitor pops and
// compares whenever the output register is consumed.
// ---------------------------------------------------------------------------
module tb_rty_cmd_sched;

  localparam int TAGW = 7;

  typedef struct packed {
    logic [TAGW-1:0] tag;
    logic [1:0]      pos;
    logic            is_retry;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            cmd_valid, cmd_rdy, cmd_partial;
  logic [TAGW-1:0] cmd_tag;
  logic [1:0]      cmd_pos;
  logic            rty_busy, rty_rdy, rty_valid;
  logic [TAGW-1:0] rty_tag;
  logic [1:0]      rty_pos;
  logic            cmd_done;
  logic            out_valid, out_rdy, out_is_retry;
  logic [TAGW-1:0] out_tag;
  logic [1:0]      out_pos;
  logic            prt_cmd_start, credit_err;
`ifdef RTY_CMD_SCHED_STATS_EN
  logic [31:0]     stat_rty_cnt, stat_stall;
  logic [15:0]     stat_win_timeout;
`endif

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  rty_cmd_sched dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_rdy       (cmd_rdy),
    .cmd_tag       (cmd_tag),
    .cmd_pos       (cmd_pos),
    .cmd_partial   (cmd_partial),
    .rty_busy      (rty_busy),
    .rty_rdy       (rty_rdy),
    .rty_valid     (rty_valid),
    .rty_tag       (rty_tag),
    .rty_pos       (rty_pos),
    .cmd_done      (cmd_done),
    .out_valid     (out_valid),
    .out_rdy       (out_rdy),
    .out_tag       (out_tag),
    .out_pos       (out_pos),
    .out_is_retry  (out_is_retry),
    .prt_cmd_start (prt_cmd_start),
    .credit_err    (credit_err)
`ifdef RTY_CMD_SCHED_STATS_EN
    ,
    .stat_rty_cnt     (stat_rty_cnt),
    .stat_win_timeout (stat_win_timeout),
    .stat_stall       (stat_stall)
`endif
  );

  // Scoreboard monitor: the entry transfers at the next rising edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_rdy === 1'b1) begin
      exp_t e;
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_underflow: got tag=%0h pos=%0d retry=%0b, required no output",
                 out_tag, out_pos, out_is_retry);
      end else begin
        e = sb.pop_front();
        if ({out_tag, out_pos, out_is_retry} !== e) begin
          n_fail++;
          $display("FAIL sb_entry: got tag=%0h pos=%0d retry=%0b, required tag=%0h pos=%0d retry=%0b",
                   out_tag, out_pos, out_is_retry, e.tag, e.pos, e.is_retry);
        end
      end
    end
  end

  // Advance to the next drive/check point, one time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [TAGW-1:0] t, input logic [1:0] p, input logic r);
    exp_t e;
    e.tag = t;
    e.pos = p;
    e.is_retry = r;
    sb.push_back(e);
  endtask

  task automatic return_credits(input int n);
    for (int i = 0; i < n; i++) begin
      cmd_done = 1'b1;
      tick();
    end
    cmd_done = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cmd_valid = 0; cmd_tag = '0; cmd_pos = '0; cmd_partial = 0;
    rty_busy = 0; rty_valid = 0; rty_tag = '0; rty_pos = '0;
    cmd_done = 0; out_rdy = 1'b1;
    #12;
    n_checks++;
    if ({out_valid, out_tag, out_pos, out_is_retry, prt_cmd_start, credit_err, rty_rdy} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%0b tag=%0h pos=%0d r=%0b prt=%0b err=%0b rty_rdy=%0b, required all 0",
               out_valid, out_tag, out_pos, out_is_retry, prt_cmd_start, credit_err, rty_rdy);
    end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (cmd_rdy !== 1'b1 || rty_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready: got cmd_rdy=%0b rty_rdy=%0b, required 1 0", cmd_rdy, rty_rdy);
    end
  endtask

  task automatic test_retry_only();
    rty_busy = 1'b1;
    #1;
    n_checks++;
    if (cmd_rdy !== 1'b1 || rty_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL rty_pre: got cmd_rdy=%0b rty_rdy=%0b, required 1 0", cmd_rdy, rty_rdy);
    end
    tick();
    n_checks++;
    if (cmd_rdy !== 1'b0 || rty_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL rty_entry: got cmd_rdy=%0b rty_rdy=%0b, required 0 1", cmd_rdy, rty_rdy);
    end
    tick();
    rty_valid = 1'b1; rty_tag = 7'h55; rty_pos = 2'd2;
    #1;
    n_checks++;
    if (rty_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL rty_offer: got rty_rdy=%0b, required 1", rty_rdy);
    end
    push_exp(7'h55, 2'd2, 1'b1);
    tick();
    rty_valid = 1'b0; rty_busy = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b1 || out_is_retry !== 1'b1 || cmd_rdy !== 1'b1 || rty_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL rty_issue: got v=%0b retry=%0b cmd_rdy=%0b rty_rdy=%0b, required 1 1 1 0",
               out_valid, out_is_retry, cmd_rdy, rty_rdy);
    end
    return_credits(1);
  endtask

  task automatic test_burst();
    cmd_valid = 1'b1; rty_busy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cmd_tag = 7'(16 + i); cmd_pos = 2'(i);
      #1;
      n_checks++;
      if (cmd_rdy !== 1'b1) begin
        n_fail++;
        $display("FAIL burst1_rdy[%0d]: got cmd_rdy=%0b, required 1", i, cmd_rdy);
      end
      push_exp(7'(16 + i), 2'(i), 1'b0);
      tick();
    end
    for (int w = 0; w < 4; w++) begin
      if (w == 3) begin
        rty_valid = 1'b1; rty_tag = 7'h66; rty_pos = 2'd1;
      end
      #1;
      n_checks++;
      if (rty_rdy !== 1'b1 || cmd_rdy !== 1'b0) begin
        n_fail++;
        $display("FAIL burst_win[%0d]: got rty_rdy=%0b cmd_rdy=%0b, required 1 0", w, rty_rdy, cmd_rdy);
      end
      if (w == 3) push_exp(7'h66, 2'd1, 1'b1);
      tick();
    end
    rty_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cmd_tag = 7'(32 + i); cmd_pos = 2'(3 - (i % 4));
      #1;
      n_checks++;
      if (cmd_rdy !== 1'b1) begin
        n_fail++;
        $display("FAIL burst2_rdy[%0d]: got cmd_rdy=%0b, required 1", i, cmd_rdy);
      end
      push_exp(7'(32 + i), 2'(3 - (i % 4)), 1'b0);
      tick();
    end
    #1;
    n_checks++;
    if (cmd_rdy !== 1'b0 || rty_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL burst_reenter: got cmd_rdy=%0b rty_rdy=%0b, required 0 1", cmd_rdy, rty_rdy);
    end
    cmd_valid = 1'b0; rty_busy = 1'b0;
    tick();
    n_checks++;
    if (cmd_rdy !== 1'b1 || rty_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL burst_idle_exit: got cmd_rdy=%0b rty_rdy=%0b, required 1 0", cmd_rdy, rty_rdy);
    end
    return_credits(17);
  endtask

  task automatic test_win_timeout();
    rty_busy = 1'b1;
    tick();
    for (int w = 0; w < 16; w++) begin
      n_checks++;
      if (rty_rdy !== 1'b1 || cmd_rdy !== 1'b0) begin
        n_fail++;
        $display("FAIL win_open[%0d]: got rty_rdy=%0b cmd_rdy=%0b, required 1 0", w, rty_rdy, cmd_rdy);
      end
      tick();
    end
    n_checks++;
    if (cmd_rdy !== 1'b1 || rty_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL win_timeout_close: got cmd_rdy=%0b rty_rdy=%0b, required 1 0", cmd_rdy, rty_rdy);
    end
`ifdef RTY_CMD_SCHED_STATS_EN
    n_checks++;
    if (stat_win_timeout !== 16'd1 || stat_rty_cnt !== 32'd2) begin
      n_fail++;
      $display("FAIL stats_window: got timeouts=%0d retries=%0d, required 1 2", stat_win_timeout, stat_rty_cnt);
    end
`endif
    rty_busy = 1'b0;
    tick();
  endtask

  task automatic test_credits();
    cmd_valid = 1'b1;
    for (int i = 0; i < 32; i++) begin
      cmd_tag = 7'(i); cmd_pos = 2'(i);
      #1;
      n_checks++;
      if (cmd_rdy !== 1'b1) begin
        n_fail++;
        $display("FAIL credit_take[%0d]: got cmd_rdy=%0b, required 1", i, cmd_rdy);
      end
      push_exp(7'(i), 2'(i), 1'b0);
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (cmd_rdy !== 1'b0) begin
        n_fail++;
        $display("FAIL credit_block[%0d]: got cmd_rdy=%0b, required 0", k, cmd_rdy);
      end
      tick();
    end
    cmd_done = 1'b1;
    tick();
    cmd_done = 1'b0; cmd_tag = 7'h7f; cmd_pos = 2'd3;
    #1;
    n_checks++;
    if (cmd_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL credit_one: got cmd_rdy=%0b, required 1", cmd_rdy);
    end
    push_exp(7'h7f, 2'd3, 1'b0);
    tick();
    n_checks++;
    if (cmd_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL credit_one_only: got cmd_rdy=%0b, required 0", cmd_rdy);
    end
    cmd_valid = 1'b0;
    tick();
    return_credits(32);
  endtask

  task automatic test_partial();
    cmd_valid = 1'b1; cmd_partial = 1'b1; cmd_tag = 7'h33; cmd_pos = 2'd1;
    #1;
    n_checks++;
    if (cmd_rdy !== 1'b1 || prt_cmd_start !== 1'b0) begin
      n_fail++;
      $display("FAIL prt_accept: got cmd_rdy=%0b prt=%0b, required 1 0", cmd_rdy, prt_cmd_start);
    end
    push_exp(7'h33, 2'd1, 1'b0);
    tick();
    cmd_valid = 1'b0; cmd_partial = 1'b0;
    n_checks++;
    if (prt_cmd_start !== 1'b1) begin
      n_fail++;
      $display("FAIL prt_pulse: got prt=%0b, required 1", prt_cmd_start);
    end
    tick();
    n_checks++;
    if (prt_cmd_start !== 1'b0) begin
      n_fail++;
      $display("FAIL prt_pulse_end: got prt=%0b, required 0", prt_cmd_start);
    end
    cmd_valid = 1'b1; cmd_tag = 7'h34; cmd_pos = 2'd0;
    push_exp(7'h34, 2'd0, 1'b0);
    tick();
    cmd_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (prt_cmd_start !== 1'b0) begin
        n_fail++;
        $display("FAIL prt_nonpartial[%0d]: got prt=%0b, required 0", k, prt_cmd_start);
      end
      tick();
    end
    return_credits(2);
  endtask

  task automatic test_backpressure();
    cmd_valid = 1'b1; cmd_tag = 7'h11; cmd_pos = 2'd2;
    #1;
    n_checks++;
    if (cmd_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_first: got cmd_rdy=%0b, required 1", cmd_rdy);
    end
    push_exp(7'h11, 2'd2, 1'b0);
    tick();
    out_rdy = 1'b0; cmd_tag = 7'h22; cmd_pos = 2'd3;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_checks++;
      if (cmd_rdy !== 1'b0 || out_valid !== 1'b1 || out_tag !== 7'h11) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got cmd_rdy=%0b v=%0b tag=%0h, required 0 1 11",
                 k, cmd_rdy, out_valid, out_tag);
      end
      tick();
    end
    out_rdy = 1'b1;
    #1;
    n_checks++;
    if (cmd_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: got cmd_rdy=%0b, required 1", cmd_rdy);
    end
    push_exp(7'h22, 2'd3, 1'b0);
    tick();
    cmd_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_tag !== 7'h22) begin
      n_fail++;
      $display("FAIL bp_reload: got v=%0b tag=%0h, required 1 22", out_valid, out_tag);
    end
    tick();
    return_credits(2);
    n_checks++;
    if (credit_err !== 1'b0) begin
      n_fail++;
      $display("FAIL credit_err_clean: got %0b, required 0", credit_err);
    end
    cmd_done = 1'b1;
    tick();
    cmd_done = 1'b0;
    tick();
    n_checks++;
    if (credit_err !== 1'b1 || cmd_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL credit_err_set: got err=%0b cmd_rdy=%0b, required 1 1", credit_err, cmd_rdy);
    end
  endtask

  initial begin
    test_reset();
    test_retry_only();
    test_burst();
    test_win_timeout();
    test_credits();
    test_partial();
    test_backpressure();
    tick();
    tick();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d entries left, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000, required finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/rty_cmd_sched.md
Name: rty_cmd_sched

Overview:
- Shares the single command-issue slot between new commands from the command engine and retry requests from the retry queue.
- Time-sliced scheduler: new commands normally own the slot; while the retry queue is busy, a bounded retry window is opened periodically. This keeps retries from starving and prevents the retry backoff countdown from blocking new traffic.
- Enforces a command credit limit on outstanding commands.
- Generates the partial-command-start pulse consumed by the retry queue.

Parameters:
- TAGW, 7, AFU tag width.
- CREDITS, 32, maximum outstanding commands (new + retry).
- CMD_BURST, 8, new-command handshakes allowed in CMD_WIN before a pending retry gets a window.
- RTY_WINDOW, 16, maximum cycles rty_rdy is offered per retry window.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  new command request
- cmd_rdy  out  1  slot offered to new command
- cmd_tag  in  TAGW  new command tag
- cmd_pos  in  2  partial position
- cmd_partial  in  1  command is partial
- rty_busy  in  1  retry queue non-empty
- rty_rdy  out  1  slot offered to retry queue
- rty_valid  in  1  retry transfer; only ever asserted while rty_rdy=1
- rty_tag  in  TAGW  retry tag
- rty_pos  in  2  retry partial position
- cmd_done  in  1  one-cycle pulse, one command completed (credit return)
- out_valid  out  1  issued command valid
- out_rdy  in  1  downstream accepts
- out_tag  out  TAGW  issued tag
- out_pos  out  2  issued position
- out_is_retry  out  1  issued entry came from the retry queue
- prt_cmd_start  out  1  pulse: partial new command accepted
- credit_err  out  1  sticky: credit return overflow

Behaviour:
- Reset values: all outputs 0; state CMD_WIN; credit_cnt=CREDITS; burst_cnt=0; win_cnt=0.
- Clocking: single clock, async active-low reset on every flop.
- slot_free = ~out_valid | out_rdy. credit_ok = (credit_cnt != 0).
- cmd_rdy = (state==CMD_WIN) & slot_free & credit_ok.
- rty_rdy = (state==RTY_WIN) & slot_free & credit_ok.
- Neither ready depends combinationally on any valid input (rty_valid is combinational on rty_rdy upstream). At most one ready is high per cycle.
- Output register, 1 entry, load on the handshake edge:
  - cmd_hs = cmd_valid & cmd_rdy loads {cmd_tag, cmd_pos, is_retry=0}.
  - rty_hs = rty_valid loads {rty_tag, rty_pos, is_retry=1}.
  - out_valid set on load, cleared on out_rdy with no new load. Input-to-output latency 1 cycle.
  - Output fields hold while out_valid & ~out_rdy.
- credit_cnt, width clog2(CREDITS)+1:
  - decrement on cmd_hs|rty_hs; increment on cmd_done; both in the same cycle leaves it unchanged.
  - cmd_done with credit_cnt==CREDITS and no handshake: count holds, credit_err set (sticky until reset).
- prt_cmd_start: registered, high the cycle after cmd_hs & cmd_partial.
- State CMD_WIN:
  - burst_cnt increments on cmd_hs.
  - Go to RTY_WIN when rty_busy & (~cmd_valid | (cmd_hs & burst_cnt==CMD_BURST-1)).
  - On entry to RTY_WIN: burst_cnt<=0, win_cnt<=0.
- State RTY_WIN:
  - win_cnt increments each cycle.
  - Go to CMD_WIN on rty_hs (one retry per window), on ~rty_busy, or on win_cnt==RTY_WINDOW-1 (timeout).
  - rty_hs takes precedence over timeout in the same cycle.
- Window gating: slot_free or credit_ok low in RTY_WIN still counts toward the window.
- Empty-retry case: rty_busy low keeps the scheduler in CMD_WIN with unlimited bursts; burst_cnt saturates at CMD_BURST-1.
- Reset mid-transfer: the output entry is discarded and credits are restored to CREDITS. The upstream/downstream reset is coincident.

Optional Feature:
- Macro RTY_CMD_SCHED_STATS_EN.
- When defined: adds outputs stat_rty_cnt [31:0] (rty_hs count), stat_win_timeout [15:0] (RTY_WIN timeouts), stat_stall [31:0] (cycles credit_ok==0). All wrap, reset to 0.
- When undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Retries only, no cmd_valid: rty_busy=1 with rty_valid one cycle after entry -> RTY_WIN, rty_rdy=1, out_is_retry=1 one cycle later, credit_cnt 32->31.
- Continuous cmd_valid, rty_busy=1 held: exactly 8 cmd_hs, then RTY_WIN. A retry given at cycle 3 of the window is issued, then 8 more cmds follow.
- Retry never responds, RTY_WINDOW=16: window closes after 16 cycles, stat_win_timeout=1, cmd_rdy reasserts the next cycle.
- CREDITS=4 with no cmd_done: 4 commands accepted, then cmd_rdy=0. One cmd_done -> exactly one more accepted.
- Backpressure: out_rdy=0 for 5 cycles -> out_tag stable, cmd_rdy=0. Release -> next command loads in the same cycle. Then cmd_done with credit_cnt=CREDITS -> credit_err=1.
- cmd_partial=1 accepted -> prt_cmd_start one-cycle pulse exactly 1 cycle after cmd_hs. A non-partial command -> no pulse.
